note_sequencer: RTL and testbench

- Drives the scoring comparator: streams reference/sung frequency pairs into it and collects per-note scores.
- Reference melody lives in an internal RAM loaded by the host; sung pitches arrive from the pitch detector via an internal FIFO.
- For each note it presents both frequencies with start, holds them until rd_en, waits for score_ready, then accumulates score.
- Sits between pitch detector/host and comparator; total score goes to the display path.

---
 rtl/note_sequencer_pkg.sv | 34 +++
 rtl/note_sequencer_freq_fifo.sv | 79 +++++++
 rtl/note_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_note_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// note_sequencer_pkg
// Shared definitions for the note sequencer: frequency/score widths, the
// comparator score codes and the sequencer state encoding.
// ---------------------------------------------------------------------------
package note_sequencer_pkg;

  // Frequency width in Hz, shared with the scoring comparator
  localparam int FREQ_W  = 15;
  localparam int SCORE_W = 4;

  // Comparator score codes
  localparam logic [SCORE_W-1:0] SCORE_MISS    = 4'd0;
  localparam logic [SCORE_W-1:0] SCORE_FAIR    = 4'd5;
  localparam logic [SCORE_W-1:0] SCORE_GOOD    = 4'd7;
  localparam logic [SCORE_W-1:0] SCORE_PERFECT = 4'd10;
  localparam logic [SCORE_W-1:0] MAX_SCORE     = SCORE_PERFECT;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_CHECK      = 3'd2,
    ST_PRESENT    = 3'd3,
    ST_WAIT_SCORE = 3'd4,
    ST_NEXT       = 3'd5,
    ST_FINISH     = 3'd6
  } state_e;

  // A reference frequency of zero marks a rest
  function automatic logic is_rest(input logic [FREQ_W-1:0] f);
    return (f == {FREQ_W{1'b0}});
  endfunction

endpackage

// File: rtl/note_sequencer_freq_fifo.sv
// ---------------------------------------------------------------------------
// freq_fifo
// Synchronous FIFO for sung frequencies. Data at the head is visible on
// o_data while not empty (fall-through read). A push while full is dropped
// and sets the sticky o_overflow flag unless a pop frees a slot in the same
// cycle.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_push, i_data  write strobe and data
//   i_pop           remove head entry (ignored when empty)
//   i_clr_ovf       clear sticky overflow
//   o_data          head entry
//   o_empty         no entries
//   o_overflow      sticky: a sample was dropped
// ---------------------------------------------------------------------------
module freq_fifo #(
  parameter int WIDTH = 15,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_clr_ovf,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;
  logic             w_drop;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == (AW+1)'(0));
  assign w_do_pop  = i_pop && !o_empty;
  // A simultaneous pop frees the slot, so a push while full still succeeds
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign w_drop    = i_push && w_full && !w_do_pop;
  assign o_data    = r_mem[r_rd_ptr];

  // Storage array write port
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and sticky overflow flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear wins so no drop is ever lost
      if (w_drop)         o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
      else                o_overflow <= o_overflow;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
// Streams reference/sung frequency pairs to the scoring comparator and
// accumulates the per-note scores. The reference melody sits in an internal
// RAM written by the host while idle; sung pitches are buffered in a FIFO.
// Ports:
//   i_clk, i_rst_n                       clock, async active-low reset
//   i_ref_wr_en/_addr/_data              host reference RAM write (IDLE only)
//   i_song_len, i_play                   song length and start pulse
//   i_sung_valid, i_sung_freq_in         pitch detector samples
//   o_start, o_ref_freq, o_sung_freq     pair presented to comparator
//   i_rd_en, i_score_ready, i_score      comparator handshake and result
//   o_total_score, o_notes_scored,
//   o_last_score                         accumulated results
//   o_busy, o_done                       status; done is a one-cycle pulse
//   o_overflow, o_timeout_err            sticky error flags (cleared on play)
// ---------------------------------------------------------------------------
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int FIFO_AW     = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ref_wr_en,
  input  logic [ADDR_W-1:0]   i_ref_wr_addr,
  input  logic [FREQ_W-1:0]   i_ref_wr_data,
  input  logic [ADDR_W:0]     i_song_len,
  input  logic                i_play,
  input  logic                i_sung_valid,
  input  logic [FREQ_W-1:0]   i_sung_freq_in,
  output logic                o_start,
  output logic [FREQ_W-1:0]   o_ref_freq,
  output logic [FREQ_W-1:0]   o_sung_freq,
  input  logic                i_rd_en,
  input  logic                i_score_ready,
  input  logic [SCORE_W-1:0]  i_score,
  output logic [ADDR_W+3:0]   o_total_score,
  output logic [ADDR_W:0]     o_notes_scored,
  output logic [SCORE_W-1:0]  o_last_score,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic                o_timeout_err
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_e              r_state;
  state_e              w_next_state;
  logic [FREQ_W-1:0]   r_ref_mem [2**ADDR_W];
  logic [ADDR_W:0]     r_song_len;
  logic [ADDR_W:0]     r_idx;
  logic [ADDR_W:0]     w_idx_inc;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                w_tmo_expired;
  logic                w_play_go;
  logic                w_pop;
  logic                w_take_score;
  logic                w_tmo_hit;
  logic [FREQ_W-1:0]   w_fifo_data;
  logic                w_fifo_empty;

  assign w_idx_inc     = r_idx + (ADDR_W+1)'(1);
  assign w_tmo_expired = (r_tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  freq_fifo #(
    .WIDTH (FREQ_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (i_sung_valid),
    .i_data     (i_sung_freq_in),
    .i_pop      (w_pop),
    .i_clr_ovf  (w_play_go),
    .o_data     (w_fifo_data),
    .o_empty    (w_fifo_empty),
    .o_overflow (o_overflow)
  );

  // Reference melody RAM, writable by the host only while idle
  always_ff @(posedge i_clk) begin
    if (i_ref_wr_en && (r_state == ST_IDLE)) begin
      r_ref_mem[i_ref_wr_addr] <= i_ref_wr_data;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state and datapath control strobes
  always_comb begin
    w_next_state = r_state;
    w_play_go    = 1'b0;
    w_pop        = 1'b0;
    w_take_score = 1'b0;
    w_tmo_hit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_play) begin
          w_play_go    = 1'b1;
          w_next_state = (i_song_len == (ADDR_W+1)'(0)) ? ST_FINISH : ST_FETCH;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_CHECK;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_CHECK: begin
        if (is_rest(o_ref_freq)) w_next_state = ST_NEXT;
        else                     w_next_state = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_rd_en) begin
          w_next_state = ST_WAIT_SCORE;
        end else if (w_tmo_expired) begin
          w_tmo_hit    = 1'b1;
          w_next_state = ST_FINISH;
        end else begin
          w_next_state = ST_PRESENT;
        end
      end
      ST_WAIT_SCORE: begin
        if (i_score_ready) begin
          w_take_score = 1'b1;
          w_next_state = ST_NEXT;
        end else if (w_tmo_expired) begin
          w_tmo_hit    = 1'b1;
          w_next_state = ST_FINISH;
        end else begin
          w_next_state = ST_WAIT_SCORE;
        end
      end
      ST_NEXT: begin
        if (w_idx_inc == r_song_len) w_next_state = ST_FINISH;
        else                         w_next_state = ST_FETCH;
      end
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Handshake timeout counter: restarts whenever PRESENT or WAIT_SCORE is entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_PRESENT) || (r_state == ST_WAIT_SCORE)) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Song bookkeeping, comparator operands and accumulated results
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_song_len     <= '0;
      r_idx          <= '0;
      o_ref_freq     <= '0;
      o_sung_freq    <= '0;
      o_total_score  <= '0;
      o_notes_scored <= '0;
      o_last_score   <= '0;
      o_timeout_err  <= 1'b0;
    end else begin
      if (w_play_go) begin
        r_song_len     <= i_song_len;
        r_idx          <= '0;
        o_total_score  <= '0;
        o_notes_scored <= '0;
        o_last_score   <= '0;
        o_timeout_err  <= 1'b0;
      end
      if (r_state == ST_NEXT) r_idx <= w_idx_inc;
      // Synchronous RAM read lines up with the FIFO pop
      if (w_pop) begin
        o_sung_freq <= w_fifo_data;
        o_ref_freq  <= r_ref_mem[r_idx[ADDR_W-1:0]];
      end
      if (w_take_score) begin
        o_total_score  <= o_total_score + {{ADDR_W{1'b0}}, i_score};
        o_notes_scored <= o_notes_scored + (ADDR_W+1)'(1);
        o_last_score   <= i_score;
      end
      if (w_tmo_hit) o_timeout_err <= 1'b1;
    end
  end

  // Status outputs registered from the next state so they track the state exactly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_start <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_start <= (w_next_state == ST_PRESENT);
      o_busy  <= (w_next_state != ST_IDLE);
      o_done  <= (w_next_state == ST_FINISH);
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
// Directed bench: a small comparator model answers each start with rd_en and
// score_ready, and each scenario checks the sequencer outputs against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int FW = 15;
  localparam int AW = 6;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic          ref_wr_en    = 1'b0;
  logic [AW-1:0] ref_wr_addr  = '0;
  logic [FW-1:0] ref_wr_data  = '0;
  logic [AW:0]   song_len     = '0;
  logic          play         = 1'b0;
  logic          sung_valid   = 1'b0;
  logic [FW-1:0] sung_freq_in = '0;
  logic          rd_en        = 1'b0;
  logic          score_ready  = 1'b0;
  logic [3:0]    score        = '0;

  logic          start;
  logic [FW-1:0] ref_freq;
  logic [FW-1:0] sung_freq;
  logic [AW+3:0] total_score;
  logic [AW:0]   notes_scored;
  logic [3:0]    last_score;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          timeout_err;

  int   checks     = 0;
  int   failures   = 0;
  int   done_seen  = 0;
  int   start_seen = 0;
  logic start_d    = 1'b0;

  note_sequencer #(
    .ADDR_W      (AW),
    .FIFO_AW     (3),
    .ACK_TIMEOUT (255)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ref_wr_en    (ref_wr_en),
    .i_ref_wr_addr  (ref_wr_addr),
    .i_ref_wr_data  (ref_wr_data),
    .i_song_len     (song_len),
    .i_play         (play),
    .i_sung_valid   (sung_valid),
    .i_sung_freq_in (sung_freq_in),
    .o_start        (start),
    .o_ref_freq     (ref_freq),
    .o_sung_freq    (sung_freq),
    .i_rd_en        (rd_en),
    .i_score_ready  (score_ready),
    .i_score        (score),
    .o_total_score  (total_score),
    .o_notes_scored (notes_scored),
    .o_last_score   (last_score),
    .o_busy         (busy),
    .o_done         (done),
    .o_overflow     (overflow),
    .o_timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Count done pulses and rising edges of start
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (start === 1'b1 && start_d !== 1'b1) start_seen++;
    start_d = start;
  end

  task automatic load_ref(input int a, input int f);
    ref_wr_en   = 1'b1;
    ref_wr_addr = a[AW-1:0];
    ref_wr_data = f[FW-1:0];
    @(negedge clk);
    ref_wr_en   = 1'b0;
  endtask

  task automatic push_sung(input int f);
    sung_valid   = 1'b1;
    sung_freq_in = f[FW-1:0];
    @(negedge clk);
    sung_valid   = 1'b0;
  endtask

  task automatic start_song(input int len);
    song_len = len[AW:0];
    play     = 1'b1;
    @(negedge clk);
    play     = 1'b0;
  endtask

  // Comparator model: waits for start, holds rd_en off for rd_delay cycles,
  // captures, then returns sc two cycles later.
  task automatic serve_note(input int rd_delay, input logic [3:0] sc,
                            input int exp_ref, input int exp_sung, input string nm);
    int n;
    logic [FW-1:0] er;
    logic [FW-1:0] es;
    er = exp_ref[FW-1:0];
    es = exp_sung[FW-1:0];
    n  = 0;
    while (start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (start !== 1'b1) begin
      failures++;
      $display("FAIL %s_start_wait: start=%b required 1", nm, start);
      return;
    end
    checks++;
    if (ref_freq !== er || sung_freq !== es) begin
      failures++;
      $display("FAIL %s_pair: ref=%0d sung=%0d required ref=%0d sung=%0d", nm, ref_freq, sung_freq, er, es);
    end
    for (int i = 0; i < rd_delay; i++) begin
      @(negedge clk);
      checks++;
      if (start !== 1'b1 || ref_freq !== er || sung_freq !== es) begin
        failures++;
        $display("FAIL %s_hold%0d: start=%b ref=%0d sung=%0d required 1/%0d/%0d", nm, i, start, ref_freq, sung_freq, er, es);
      end
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_drop: start=%b required 0", nm, start);
    end
    repeat (2) @(negedge clk);
    score       = sc;
    score_ready = 1'b1;
    @(negedge clk);
    score_ready = 1'b0;
    checks++;
    if (last_score !== sc) begin
      failures++;
      $display("FAIL %s_last_score: got %0d required %0d", nm, last_score, sc);
    end
  endtask

  task automatic wait_done(input int bound, input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: done=%b required 1 within %0d cycles", nm, done, bound);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_done: done=%b busy=%b required 0/0", nm, done, busy);
    end
  endtask

  task automatic check_totals(input int tot, input int cnt, input string nm);
    checks++;
    if (total_score !== tot[AW+3:0] || notes_scored !== cnt[AW:0]) begin
      failures++;
      $display("FAIL %s_totals: total=%0d notes=%0d required %0d/%0d", nm, total_score, notes_scored, tot, cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({start, ref_freq, sung_freq, total_score, notes_scored, last_score, busy, done, overflow, timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: start=%b busy=%b done=%b total=%0d required all 0", start, busy, done, total_score);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || start !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b start=%b required 0/0/0", busy, done, start);
    end
  endtask

  task automatic test_basic();
    int d0;
    int s0;
    d0 = done_seen;
    s0 = start_seen;
    load_ref(0, 440); load_ref(1, 0); load_ref(2, 220);
    push_sung(440); push_sung(100); push_sung(221);
    start_song(3);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    serve_note(1, 4'd10, 440, 440, "basic_n0");
    serve_note(1, 4'd7, 220, 221, "basic_n2");
    wait_done(20, "basic");
    check_totals(17, 2, "basic");
    checks++;
    if (last_score !== 4'd7 || done_seen - d0 != 1 || start_seen - s0 != 2) begin
      failures++;
      $display("FAIL basic_counts: last=%0d dones=%0d starts=%0d required 7/1/2", last_score, done_seen - d0, start_seen - s0);
    end
  endtask

  task automatic test_rd_delay();
    load_ref(0, 440);
    push_sung(440);
    start_song(1);
    serve_note(5, 4'd10, 440, 440, "rd_delay");
    wait_done(20, "rd_delay");
    check_totals(10, 1, "rd_delay");
  endtask

  task automatic test_timeout();
    int n;
    int d0;
    d0 = done_seen;
    load_ref(0, 300);
    push_sung(300);
    start_song(1);
    n = 0;
    while (start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (start !== 1'b1 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_present: start=%b timeout_err=%b required 1/0", start, timeout_err);
    end
    n = 0;
    while (start === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 255) begin
      failures++;
      $display("FAIL tmo_cycles: start high %0d cycles required 255", n);
    end
    checks++;
    if (timeout_err !== 1'b1 || start !== 1'b0) begin
      failures++;
      $display("FAIL tmo_flag: timeout_err=%b start=%b required 1/0", timeout_err, start);
    end
    wait_done(5, "tmo");
    check_totals(0, 0, "tmo");
    checks++;
    if (done_seen - d0 != 1 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_done_count: dones=%0d timeout_err=%b required 1/1", done_seen - d0, timeout_err);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) push_sung(1000 + i);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: overflow=%b required 1", overflow);
    end
    for (int i = 0; i < 8; i++) load_ref(i, 1000 + i);
    start_song(8);
    checks++;
    if (overflow !== 1'b0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: overflow=%b timeout_err=%b required 0/0", overflow, timeout_err);
    end
    for (int i = 0; i < 8; i++) serve_note(0, 4'd10, 1000 + i, 1000 + i, "ovf_note");
    wait_done(20, "ovf");
    check_totals(80, 8, "ovf");
  endtask

  task automatic test_empty_song();
    int d0;
    int s0;
    d0 = done_seen;
    s0 = start_seen;
    start_song(0);
    wait_done(2, "empty");
    repeat (3) @(negedge clk);
    check_totals(0, 0, "empty");
    checks++;
    if (done_seen - d0 != 1 || start_seen - s0 != 0) begin
      failures++;
      $display("FAIL empty_counts: dones=%0d starts=%0d required 1/0", done_seen - d0, start_seen - s0);
    end
  endtask

  task automatic test_reset_mid_song();
    int n;
    int d0;
    load_ref(0, 500); load_ref(1, 600);
    push_sung(500); push_sung(600);
    start_song(2);
    serve_note(0, 4'd5, 500, 500, "mid_n0");
    n = 0;
    while (start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_totals(5, 1, "mid_before_rst");
    d0 = done_seen;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({start, ref_freq, sung_freq, total_score, notes_scored, last_score, busy, done, overflow, timeout_err} !== '0) begin
      failures++;
      $display("FAIL mid_async_reset: total=%0d busy=%b ref=%0d sung=%0d required all 0", total_score, busy, ref_freq, sung_freq);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_seen != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_done: dones=%0d busy=%b required 0/0", done_seen - d0, busy);
    end
    load_ref(0, 500); load_ref(1, 600);
    push_sung(500); push_sung(600);
    start_song(2);
    serve_note(0, 4'd10, 500, 500, "rerun_n0");
    serve_note(0, 4'd7, 600, 600, "rerun_n1");
    wait_done(20, "rerun");
    check_totals(17, 2, "rerun");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rd_delay();
    test_timeout();
    test_overflow();
    test_empty_song();
    test_reset_mid_song();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
